// File: rtl/dsp_reg_pkg.sv
`default_nettype none
// ============================================================================
// dsp_reg_pkg -- DSP register map constants, master FSM states, request record.
// Optional: DSP_REG_MASTER_VERIFY_EN adds the write read-back verify state.
// Rev 1.0
// ============================================================================
package dsp_reg_pkg;

  localparam logic [7:0] ADDR_KON  = 8'h4C;
  localparam logic [7:0] ADDR_KOFF = 8'h5C;
  localparam logic [7:0] ADDR_FLG  = 8'h6C;
  localparam logic [7:0] ADDR_ENDX = 8'h7C;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ_WAIT = 3'd2,
    ST_RESP      = 3'd3
`ifdef DSP_REG_MASTER_VERIFY_EN
    , ST_VERIFY_WAIT = 3'd4
`endif
  } master_state_e;

  typedef struct packed {
    logic       write;
    logic [7:0] address;
    logic [7:0] data;
  } dsp_req_t;

`ifdef DSP_REG_MASTER_VERIFY_EN
  // ENDX is cleared by the DSP itself, so its read-back never matches the written value.
  function automatic logic verify_exempt(input logic [7:0] address);
    return address == ADDR_ENDX;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/dsp_reg_req_fifo.sv
`default_nettype none
// ============================================================================
// dsp_reg_req_fifo -- synchronous request queue with registered full/empty flags.
// Rev 1.0
// ============================================================================
module dsp_reg_req_fifo
  import dsp_reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  dsp_req_t push_data,
  input  logic     pop,
  output dsp_req_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  dsp_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // Flags are registered from the next count, so a fresh entry is only visible next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsp_reg_master.sv
`default_nettype none
// ============================================================================
// dsp_reg_master -- queued initiator serialising register requests onto the DSP bus.
// Optional: DSP_REG_MASTER_VERIFY_EN reads back every write and flags mismatches.
// Rev 1.0
// ============================================================================
module dsp_reg_master
  import dsp_reg_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_address,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_address,
  output logic [7:0] rsp_data,
  output logic [7:0] dsp_reg_address,
  output logic [7:0] dsp_reg_data_in,
  input  logic [7:0] dsp_reg_data_out,
  output logic       dsp_reg_write_enable,
  output logic       busy
`ifdef DSP_REG_MASTER_VERIFY_EN
  ,
  output logic       verify_error
`endif
);

  localparam logic [1:0] RL_INIT = 2'(READ_LATENCY);

  master_state_e state;
  logic [1:0]    cnt;
  logic          ready_en;
  dsp_req_t      push_req;
  dsp_req_t      head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign push_req  = '{write: req_write, address: req_address, data: req_data};
  assign req_ready = ready_en & ~fifo_full;
  assign push      = req_valid & req_ready;
  assign busy      = ~fifo_empty | (state != ST_IDLE);

`ifdef DSP_REG_MASTER_VERIFY_EN
  assign pop = ~fifo_empty & (state == ST_IDLE);
`else
  // Popping straight out of WRITE gives back-to-back writes at one per cycle.
  assign pop = ~fifo_empty & ((state == ST_IDLE) | (state == ST_WRITE));
`endif

  dsp_reg_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      ready_en             <= 1'b0;
      dsp_reg_address      <= '0;
      dsp_reg_data_in      <= '0;
      dsp_reg_write_enable <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_address          <= '0;
      rsp_data             <= '0;
`ifdef DSP_REG_MASTER_VERIFY_EN
      verify_error         <= 1'b0;
`endif
    end else begin
      ready_en             <= 1'b1;
      dsp_reg_write_enable <= 1'b0;
      if (pop) begin
        dsp_reg_address      <= head.address;
        dsp_reg_data_in      <= head.data;
        dsp_reg_write_enable <= head.write;
        cnt                  <= RL_INIT;
        state                <= head.write ? ST_WRITE : ST_READ_WAIT;
      end else begin
        case (state)
          ST_WRITE: begin
`ifdef DSP_REG_MASTER_VERIFY_EN
            cnt   <= RL_INIT;
            state <= ST_VERIFY_WAIT;
`else
            state <= ST_IDLE;
`endif
          end
          ST_READ_WAIT: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              rsp_data    <= dsp_reg_data_out;
              rsp_address <= dsp_reg_address;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
`ifdef DSP_REG_MASTER_VERIFY_EN
          // Address and data are still held from the write, so the read-back compares against them.
          ST_VERIFY_WAIT: begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) begin
              if (!verify_exempt(dsp_reg_address) && (dsp_reg_data_out != dsp_reg_data_in)) begin
                verify_error <= 1'b1;
              end
              state <= ST_IDLE;
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
